// File: rtl/rbz_spi_pkg.sv
// Shared definitions for the rbzero register-port SPI host: command codes,
// default field widths and the host FSM state encoding.
package rbz_spi_pkg;

  localparam int CMD_W_DEF  = 4;
  localparam int DATA_W_DEF = 24;
  localparam int LEN_W_DEF  = 5;

  localparam logic [3:0] CMD_NOP       = 4'h0;
  localparam logic [3:0] CMD_SET_SKY   = 4'h1;
  localparam logic [3:0] CMD_SET_FLOOR = 4'h2;
  localparam logic [3:0] CMD_SET_LEAK  = 4'h3;
  localparam logic [3:0] CMD_SET_VINF  = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HI,
    ST_LO,
    ST_GAP
  } host_state_e;

endpackage

// File: rtl/rbz_reg_spi_host_queue.sv
// Two-entry request FIFO placed ahead of the SPI host FSM.
// Only built when RBZ_REG_SPI_HOST_QUEUE_EN is defined.
`ifdef RBZ_REG_SPI_HOST_QUEUE_EN
module rbz_reg_spi_host_queue
  import rbz_spi_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_pop
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic [1:0]   cnt_q, cnt_d;
  logic         ready_q, ready_d;
  logic         push, pop;
  logic [1:0]   wr_idx;

  assign push = i_push && ready_q;
  assign pop  = i_pop && (cnt_q != 2'd0);

  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      cnt_d    = cnt_q - 2'd1;
      wr_idx   = cnt_q - 2'd1;
    end
    if (push) begin
      mem_d[wr_idx[0]] = i_data;
      cnt_d            = cnt_d + 2'd1;
    end
    ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      cnt_q   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = (cnt_q != 2'd0);
  assign o_data  = mem_q[0];

endmodule
`endif

// File: rtl/rbz_reg_spi_host.sv
// SPI mode-0 host serialising {cmd, payload} register frames onto rbzero's register port.
// Define RBZ_REG_SPI_HOST_QUEUE_EN to add a 2-entry request FIFO in front of the FSM.
module rbz_reg_spi_host
  import rbz_spi_pkg::*;
#(
  parameter int CMD_W      = CMD_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_reg_ss_n,
  output logic              o_reg_sclk,
  output logic              o_reg_mosi
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  host_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic ss_n_q, ss_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic done_q, done_d, busy_q, busy_d, ready_q, ready_d;

  logic              req_valid, start, active;
  logic [CMD_W-1:0]  req_cmd;
  logic [DATA_W-1:0] req_data, data_al;
  logic [LEN_W-1:0]  req_len, len_c;

`ifdef RBZ_REG_SPI_HOST_QUEUE_EN
  localparam int REQ_W = CMD_W + DATA_W + LEN_W;
  logic [REQ_W-1:0] req_flat;
  logic             fifo_ready;

  rbz_reg_spi_host_queue #(.W(REQ_W)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (i_valid),
    .i_data  ({i_cmd, i_data, i_len}),
    .o_ready (fifo_ready),
    .o_valid (req_valid),
    .o_data  (req_flat),
    .i_pop   (start)
  );

  assign {req_cmd, req_data, req_len} = req_flat;
  assign o_ready = fifo_ready;
  assign o_busy  = busy_q | req_valid;
`else
  assign req_valid = i_valid;
  assign req_cmd   = i_cmd;
  assign req_data  = i_data;
  assign req_len   = i_len;
  assign o_ready   = ready_q;
  assign o_busy    = busy_q;
`endif

  // Payload is left-aligned under the command so the frame always shifts out of the MSB.
  assign len_c   = (req_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : req_len;
  assign data_al = req_data << (LEN_W'(DATA_W) - len_c);
  assign start   = (state_q == ST_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        frame_d = {req_cmd, data_al};
        bits_d  = BIT_W'(CMD_W) + BIT_W'(len_c);
        cnt_d   = DIV_LOAD;
        state_d = ST_LEAD;
      end
      ST_LEAD: if (cnt_q == '0) begin
        cnt_d   = DIV_LOAD;
        state_d = ST_HI;
      end else cnt_d = cnt_q - 1'b1;
      ST_HI: if (cnt_q == '0) begin
        cnt_d   = DIV_LOAD;
        frame_d = frame_q << 1;
        bits_d  = (bits_q == '0) ? '0 : bits_q - 1'b1;
        state_d = ST_LO;
      end else cnt_d = cnt_q - 1'b1;
      ST_LO: if (cnt_q == '0) begin
        if (bits_q == '0) begin
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d   = DIV_LOAD;
          state_d = ST_HI;
        end
      end else cnt_d = cnt_q - 1'b1;
      ST_GAP: if (cnt_q == '0) state_d = ST_IDLE;
              else cnt_d = cnt_q - 1'b1;
      default: state_d = ST_IDLE;
    endcase

    active  = (state_d == ST_LEAD) || (state_d == ST_HI) || (state_d == ST_LO);
    ss_n_d  = !active;
    sclk_d  = (state_d == ST_HI);
    mosi_d  = active && frame_d[FRAME_W-1];
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      frame_q <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      frame_q <= frame_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign o_reg_ss_n = ss_n_q;
  assign o_reg_sclk = sclk_q;
  assign o_reg_mosi = mosi_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_rbz_reg_spi_host.sv
// Self-checking bench for rbz_reg_spi_host: a register-receiver model decodes the SPI
// lines and frames are compared with values derived from the request fields.
module tb_rbz_reg_spi_host;

  localparam int CMD_W = 4, DATA_W = 24, LEN_W = 5, CLK_DIV = 2, GAP_CYCLES = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0;
  logic [CMD_W-1:0]  cmd = '0;
  logic [DATA_W-1:0] data = '0;
  logic [LEN_W-1:0]  len = '0;
  logic ready, busy, done, ss_n, sclk, mosi;

  always #5 clk = ~clk;

  rbz_reg_spi_host #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(rst), .i_valid(valid), .o_ready(ready),
    .i_cmd(cmd), .i_data(data), .i_len(len), .o_busy(busy), .o_done(done),
    .o_reg_ss_n(ss_n), .o_reg_sclk(sclk), .o_reg_mosi(mosi)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: sample MOSI on each SCLK rise while ss_n is low, close the frame on ss_n rise.
  logic prev_ss = 1'b1, prev_sclk = 1'b0;
  longint cur_val = 0;
  int cur_n = 0, low_cnt = 0, high_cnt = 0, done_cnt = 0;
  longint q_val[$];
  int q_n[$], q_low[$], q_done[$], q_high[$];

  always @(negedge clk) begin
    if (rst) begin
      cur_val = 0; cur_n = 0; low_cnt = 0; high_cnt = 0;
      prev_ss = 1'b1; prev_sclk = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (!ss_n) begin
        if (prev_ss) begin
          q_high.push_back(high_cnt);
          cur_val = 0; cur_n = 0; low_cnt = 0;
        end
        low_cnt++;
        if (sclk && !prev_sclk) begin
          cur_val = (cur_val << 1) | longint'(mosi);
          cur_n++;
        end
      end else begin
        if (!prev_ss) begin
          q_val.push_back(cur_val); q_n.push_back(cur_n);
          q_low.push_back(low_cnt); q_done.push_back(int'(done));
          high_cnt = 0;
        end
        high_cnt++;
      end
      prev_ss = ss_n; prev_sclk = sclk;
    end
  end

  // Expected requests in issue order.
  logic [3:0]  e_cmd[$];
  logic [23:0] e_data[$];
  logic [4:0]  e_len[$];
  int frames_done = 0;

  task automatic send(input logic [3:0] c, input logic [23:0] d, input logic [4:0] l);
    int t;
    @(negedge clk);
    valid = 1'b1; cmd = c; data = d; len = l;
    t = 0;
    while (!ready && t < 5000) begin @(negedge clk); t++; end
    chk("ready_wait_bound", 64'(t >= 5000), 0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    cmd = 4'($urandom); data = 24'($urandom); len = 5'($urandom);
    chk("ready_low_after_accept", 64'(ready), 0);
    chk("busy_after_accept", 64'(busy), 1);
    e_cmd.push_back(c); e_data.push_back(d); e_len.push_back(l);
  endtask

  task automatic check_next(output int high_before);
    int t, lc, n, exp_low;
    longint exp_val;
    logic [3:0] c; logic [23:0] d; logic [4:0] l;
    high_before = 0;
    t = 0;
    while (q_val.size() == 0 && t < 5000) begin @(negedge clk); t++; end
    chk("frame_wait_bound", 64'(q_val.size() == 0), 0);
    if (q_val.size() != 0 && e_cmd.size() != 0) begin
      c = e_cmd.pop_front(); d = e_data.pop_front(); l = e_len.pop_front();
      lc = (int'(l) > DATA_W) ? DATA_W : int'(l);
      n = CMD_W + lc;
      exp_val = (longint'(c) << lc) | (longint'(d) & ((longint'(1) << lc) - 1));
      exp_low = CLK_DIV * (2 * n + 1);
      chk("frame_bits", 64'(q_val.pop_front()), 64'(exp_val));
      chk("frame_edges", 64'(q_n.pop_front()), 64'(n));
      chk("ss_n_low_cycles", 64'(q_low.pop_front()), 64'(exp_low));
      chk("done_at_ss_rise", 64'(q_done.pop_front()), 1);
      high_before = q_high.pop_front();
      frames_done++;
    end
  endtask

  initial begin
    int hb, t, nfr;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    chk("idle_ss_n", 64'(ss_n), 1);
    chk("idle_sclk", 64'(sclk), 0);
    chk("idle_mosi", 64'(mosi), 0);
    chk("idle_ready", 64'(ready), 1);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_no_done", 64'(done_cnt), 0);

    // 0xA + 8'h5C: 12 edges, 50 cycles low
    send(4'hA, 24'h00005C, 5'd8);
    check_next(hb);
    chk("frame_a5c_low50", 64'(CLK_DIV * 25), 64'(50));
    chk("done_count_1", 64'(done_cnt), 1);

    // Command-only frame
    send(4'h3, 24'hFFFFFF, 5'd0);
    check_next(hb);
    repeat (GAP_CYCLES + 2) @(negedge clk);
    chk("idle_after_gap_busy", 64'(busy), 0);
    chk("idle_after_gap_ready", 64'(ready), 1);

    // Back-to-back: second request waits for ready
    send(4'h5, 24'h123456, 5'd16);
    send(4'hC, 24'hABCDEF, 5'd24);
    check_next(hb);
    check_next(hb);
    chk("b2b_gap_ge_min", 64'(hb >= GAP_CYCLES), 1);

    // Length clamp: 31 -> 24 payload bits, 28 edges
    send(4'h7, 24'hC3A5F0, 5'd31);
    check_next(hb);

    // Reset while SCLK is high: abandon frame, no done
    nfr = frames_done;
    t = done_cnt;
    send(4'h9, 24'h5A5A5A, 5'd20);
    hb = 0;
    while (!sclk && hb < 200) begin @(negedge clk); hb++; end
    chk("reach_hi_bound", 64'(hb >= 200), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ss_n", 64'(ss_n), 1);
    chk("rst_mid_sclk", 64'(sclk), 0);
    chk("rst_mid_mosi", 64'(mosi), 0);
    chk("rst_mid_ready", 64'(ready), 1);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_done", 64'(done), 0);
    void'(e_cmd.pop_back()); void'(e_data.pop_back()); void'(e_len.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_frame", 64'(q_val.size()), 0);
    chk("rst_no_done", 64'(done_cnt), 64'(t));
    q_high.delete();

    // Random frames, mostly back-to-back
    for (int i = 0; i < 24; i++) begin
      send(4'($urandom), 24'($urandom), 5'($urandom_range(0, 31)));
      if (i % 2 == 1) begin
        check_next(hb);
        check_next(hb);
        chk("rand_gap_ge_min", 64'(hb >= GAP_CYCLES), 1);
      end
    end
    chk("done_total", 64'(done_cnt), 64'(frames_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
